// File: rtl/dphy_byte_align.sv
// ---------------------------------------------------------------------------
// dphy_byte_align
// Per-lane HS byte aligner for the CSI-2 D-PHY receive path. While the
// settle-ignore qualifier is high it hunts for the HS sync byte at any of the
// eight bit offsets of a 16-bit window, locks to the lowest matching offset,
// and then emits byte-aligned payload until the burst ends. The sync byte
// itself is consumed and never forwarded.
//
// Parameters
//   SYNC_BYTE       HS-SoT sync pattern, bit 0 first on the wire
//   SEARCH_TIMEOUT  qualified search cycles allowed before a sync error (>= 2)
//
// Ports
//   clk_i            byte clock from the deserializer
//   rst_n_i          asynchronous active-low reset
//   hs_data_valid_i  HS qualifier from the settle-ignore stage
//   data_i[7:0]      raw deserialized word, bit 0 earliest on the wire
//   byte_o[7:0]      aligned payload byte (holds when byte_valid_o is low)
//   byte_valid_o     byte_o carries payload this cycle
//   sync_found_o     one-cycle pulse when the sync byte is locked
//   sync_err_o       one-cycle pulse when the search times out
// ---------------------------------------------------------------------------
module dphy_byte_align #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hB8,
  parameter int unsigned SEARCH_TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       hs_data_valid_i,
  input  logic [7:0] data_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       sync_found_o,
  output logic       sync_err_o
);

  localparam int unsigned CNT_W = $clog2(SEARCH_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SEARCH_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SEARCH_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE_S    = 2'd0,
    SEARCH_S  = 2'd1,
    ALIGNED_S = 2'd2,
    ERR_S     = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_prev;
  logic [2:0]       r_offset;
  logic [2:0]       w_offset_nxt;
  logic [CNT_W-1:0] r_search_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [7:0]       r_byte;
  logic [7:0]       w_byte_nxt;
  logic             r_byte_valid;
  logic             w_byte_valid_nxt;
  logic             r_sync_found;
  logic             w_sync_found_nxt;
  logic             r_sync_err;
  logic             w_sync_err_nxt;

  logic [15:0]      w_win;
  logic             w_match;
  logic [2:0]       w_match_k;
  logic [7:0]       w_aligned;

  // Current word on top of the previous one: a byte starting at bit k of the
  // previous word is w_win[k+7:k].
  assign w_win = {data_i, r_prev};

  // Lowest matching offset wins: scan downwards so lower k overrides.
  always_comb begin
    w_match   = 1'b0;
    w_match_k = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (w_win[k +: 8] == SYNC_BYTE) begin
        w_match   = 1'b1;
        w_match_k = 3'(k);
      end
    end
  end

  // Payload extraction at the locked offset.
  assign w_aligned = w_win[r_offset +: 8];

  // Saturating search counter increment.
  assign w_cnt_inc = (r_search_cnt == CNT_MAX) ? r_search_cnt
                                               : r_search_cnt + CNT_W'(1);

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_offset_nxt     = r_offset;
    w_cnt_nxt        = r_search_cnt;
    w_byte_nxt       = r_byte;
    w_byte_valid_nxt = 1'b0;
    w_sync_found_nxt = 1'b0;
    w_sync_err_nxt   = 1'b0;

    case (r_state)
      IDLE_S, SEARCH_S: begin
        if (!hs_data_valid_i) begin
          // Burst ended before lock: quietly start over.
          w_state_nxt = IDLE_S;
          w_cnt_nxt   = '0;
        end else if (w_match) begin
          // A match on the final allowed search cycle still wins.
          w_state_nxt      = ALIGNED_S;
          w_offset_nxt     = w_match_k;
          w_sync_found_nxt = 1'b1;
          w_cnt_nxt        = '0;
        end else if (r_search_cnt >= CNT_LAST) begin
          w_state_nxt    = ERR_S;
          w_sync_err_nxt = 1'b1;
          w_cnt_nxt      = w_cnt_inc;
        end else begin
          w_state_nxt = SEARCH_S;
          w_cnt_nxt   = w_cnt_inc;
        end
      end

      ALIGNED_S: begin
        if (hs_data_valid_i) begin
          w_byte_nxt       = w_aligned;
          w_byte_valid_nxt = 1'b1;
        end else begin
          w_state_nxt = IDLE_S;
        end
      end

      ERR_S: begin
        // Discard the rest of the burst.
        if (!hs_data_valid_i) begin
          w_state_nxt = IDLE_S;
          w_cnt_nxt   = '0;
        end
      end

      default: begin
        w_state_nxt = IDLE_S;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= IDLE_S;
      r_prev       <= 8'h00;
      r_offset     <= 3'd0;
      r_search_cnt <= '0;
      r_byte       <= 8'h00;
      r_byte_valid <= 1'b0;
      r_sync_found <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      // Outside a burst the history word is zeroed so a new burst never
      // matches against stale bits.
      r_prev       <= hs_data_valid_i ? data_i : 8'h00;
      r_offset     <= w_offset_nxt;
      r_search_cnt <= w_cnt_nxt;
      r_byte       <= w_byte_nxt;
      r_byte_valid <= w_byte_valid_nxt;
      r_sync_found <= w_sync_found_nxt;
      r_sync_err   <= w_sync_err_nxt;
    end
  end

  assign byte_o       = r_byte;
  assign byte_valid_o = r_byte_valid;
  assign sync_found_o = r_sync_found;
  assign sync_err_o   = r_sync_err;

endmodule

// File: tb/tb_dphy_byte_align.sv
// ---------------------------------------------------------------------------
// tb_dphy_byte_align
// Directed bench for dphy_byte_align. Expected bytes, sync_found and
// sync_err pulses are queued with their due cycle when the stimulus is
// driven and compared every cycle as the DUT produces output.
// ---------------------------------------------------------------------------
module tb_dphy_byte_align;

  localparam logic [7:0] SYNC = 8'hB8;

  typedef struct {
    int unsigned t;
    logic [7:0]  b;
  } exp_byte_t;

  logic       clk;
  logic       rst_n;
  logic       hs_valid;
  logic [7:0] data;
  logic [7:0] byte_o;
  logic       byte_valid;
  logic       sync_found;
  logic       sync_err;

  int unsigned n_assert;
  int unsigned n_fail;
  int unsigned cyc;
  logic [7:0]  last_byte;

  exp_byte_t   bq[$];
  int unsigned fq[$];
  int unsigned eq[$];

  dphy_byte_align dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .hs_data_valid_i (hs_valid),
    .data_i          (data),
    .byte_o          (byte_o),
    .byte_valid_o    (byte_valid),
    .sync_found_o    (sync_found),
    .sync_err_o      (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cycle %0d: observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // Compare all outputs against whatever is due this cycle.
  task automatic check_outputs();
    logic exp_f;
    logic exp_e;
    if (bq.size() != 0 && bq[0].t == cyc) begin
      check("byte_valid", 8'(byte_valid), 8'h01);
      check("byte", byte_o, bq[0].b);
      last_byte = bq[0].b;
      void'(bq.pop_front());
    end else begin
      check("byte_valid_idle", 8'(byte_valid), 8'h00);
      check("byte_hold", byte_o, last_byte);
    end
    exp_f = (fq.size() != 0 && fq[0] == cyc);
    if (exp_f) void'(fq.pop_front());
    check("sync_found", 8'(sync_found), 8'(exp_f));
    exp_e = (eq.size() != 0 && eq[0] == cyc);
    if (exp_e) void'(eq.pop_front());
    check("sync_err", 8'(sync_err), 8'(exp_e));
  endtask

  // One byte-clock cycle of stimulus, then sample just after the edge.
  task automatic drive(input logic v, input logic [7:0] d);
    hs_valid = v;
    data     = d;
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  // Burst of: `lead` zero bits, sync byte, npay payload bytes (pay[7:0]
  // first), LSB-first packed, padded so the last payload byte is flushed;
  // followed by one qualifier-low cycle.
  task automatic sync_burst(input int unsigned lead, input int unsigned npay,
                            input logic [31:0] pay);
    logic [255:0] bs;
    int unsigned  t0;
    int unsigned  n;
    int unsigned  nw;
    logic [2:0]   k;
    exp_byte_t    e;
    bs = '0;
    bs[lead +: 8] = SYNC;
    for (int i = 0; i < int'(npay); i++) bs[lead + 8 + 8*i +: 8] = pay[8*i +: 8];
    nw = (lead + 8*npay) / 8 + 2;
    t0 = cyc;
    n  = t0 + lead / 8 + 1;       // cycle whose window holds the sync
    k  = 3'(lead % 8);
    fq.push_back(n + 1);
    for (int i = 0; i < int'(npay); i++) begin
      e.t = n + 2 + 32'(i);
      e.b = pay[8*i +: 8];
      bq.push_back(e);
    end
    for (int w = 0; w < int'(nw); w++) begin
      drive(1'b1, bs[8*w +: 8]);
      if (cyc == n + 1) check("offset_q", 8'(dut.r_offset), 8'(k));
    end
    drive(1'b0, 8'h00);
  endtask

  initial begin
    exp_byte_t e;
    n_assert  = 0;
    n_fail    = 0;
    cyc       = 0;
    last_byte = 8'h00;
    rst_n     = 1'b1;
    hs_valid  = 1'b0;
    data      = 8'h00;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_byte", byte_o, 8'h00);
    check("rst_byte_valid", 8'(byte_valid), 8'h00);
    check("rst_sync_found", 8'(sync_found), 8'h00);
    check("rst_sync_err", 8'(sync_err), 8'h00);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);

    // Aligned sync: 00, B8, 11, 22, 33 (+ flush word)
    sync_burst(8, 3, 32'h00332211);

    // Offset sweep k = 1..7
    for (int k = 1; k <= 7; k++) sync_burst(32'(8 + k), 3, 32'h00FF5AA5);

    // Timeout: err after the 16th unmatched search cycle, then recovery
    eq.push_back(cyc + 16);
    for (int i = 0; i < 20; i++) drive(1'b1, 8'h00);
    drive(1'b0, 8'h00);
    sync_burst(8, 3, 32'h00445566);

    // Burst end: one-cycle gap, then a new sync with payload 0x77
    sync_burst(8, 2, 32'h00002211);
    sync_burst(8, 1, 32'h00000077);

    // Reset mid-burst while streaming
    begin
      int unsigned t0;
      t0 = cyc;
      fq.push_back(t0 + 3);
      e.t = t0 + 4; e.b = 8'h11; bq.push_back(e);
      e.t = t0 + 5; e.b = 8'h22; bq.push_back(e);
      drive(1'b1, 8'h00);
      drive(1'b1, SYNC);
      drive(1'b1, 8'h11);
      drive(1'b1, 8'h22);
      drive(1'b1, 8'h33);
      #3 rst_n = 1'b0;
      #1;
      check("mid_rst_byte", byte_o, 8'h00);
      check("mid_rst_byte_valid", 8'(byte_valid), 8'h00);
      check("mid_rst_sync_found", 8'(sync_found), 8'h00);
      check("mid_rst_sync_err", 8'(sync_err), 8'h00);
      bq.delete();
      last_byte = 8'h00;
      #2 rst_n = 1'b1;
      // Qualifier stays high; sync only after five zero words
      sync_burst(40, 1, 32'h0000005C);
    end

    // Abort during search, then sync on the 15th word of the next burst:
    // detection lands on the 16th search cycle, where a match beats timeout
    for (int i = 0; i < 10; i++) drive(1'b1, 8'h00);
    drive(1'b0, 8'h00);
    sync_burst(112, 1, 32'h0000003C);

    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);

    check("pending_bytes", 8'(bq.size()), 8'h00);
    check("pending_found", 8'(fq.size()), 8'h00);
    check("pending_err", 8'(eq.size()), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
